if_stage: RTL and testbench

Instruction-fetch stage of the five-stage MIPS pipeline; the producer end of the IF→ID interface. It owns the PC register, drives the instruction SRAM request whose read data the decode stage consumes one cycle later, and applies the branch/jump redirect that decode returns on `br_bus`. It holds its PC under pipeline stall and captures a redirect that arrives while stalled, so no branch target is lost.

---
 rtl/if_stage.sv | 88 ++++++++
 tb/tb_if_stage.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction SRAM request and
// applies decode's branch/jump redirect, holding a redirect captured while stalled.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [5:0]  stall,
    input  logic [32:0] br_bus,
    output logic [32:0] if_to_id_bus,
    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_wen,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata
);

    typedef enum logic [1:0] {BOOT, RUN, HOLD} st_t;

    st_t         st;
    logic [31:0] pc_reg;
    logic        ce_reg;
    logic        pend_valid;
    logic [31:0] pend_addr;
    logic [31:0] next_pc;

    logic        stop;
    logic        br_e;
    logic [31:0] br_addr;
    logic        unused_stall;

    assign stop         = stall[0];
    assign unused_stall = ^stall[5:1];
    assign br_e         = br_bus[32];
    assign br_addr      = br_bus[31:0];

    // A live redirect is the newer decision, so it outranks a captured one.
    always_comb begin
        next_pc = pc_reg + 32'd4;
        if (br_e)
            next_pc = br_addr;
        else if (pend_valid)
            next_pc = pend_addr;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            st         <= BOOT;
            pc_reg     <= RESET_PC - 32'd4;
            ce_reg     <= 1'b0;
            pend_valid <= 1'b0;
            pend_addr  <= 32'd0;
        end else begin
            case (st)
                BOOT: begin
                    if (!stop) begin
                        st     <= RUN;
                        pc_reg <= next_pc;
                        ce_reg <= 1'b1;
                    end else begin
                        ce_reg <= 1'b0;
                    end
                end
                RUN, HOLD: begin
                    if (!stop) begin
                        st         <= RUN;
                        pc_reg     <= next_pc;
                        pend_valid <= 1'b0;
                    end else begin
                        st <= HOLD;
                        // Only the first redirect of a stall window is kept.
                        if (br_e && !pend_valid) begin
                            pend_valid <= 1'b1;
                            pend_addr  <= br_addr;
                        end
                    end
                end
                default: st <= BOOT;
            endcase
        end
    end

    assign if_to_id_bus    = {ce_reg, pc_reg};
    assign inst_sram_en    = ce_reg;
    assign inst_sram_wen   = 4'b0;
    assign inst_sram_addr  = pc_reg;
    assign inst_sram_wdata = 32'b0;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus random stall/branch
// traffic compared against a behavioural fetch model.
module tb_if_stage;

    logic        clk;
    logic        resetn;
    logic [5:0]  stall;
    logic [32:0] br_bus;
    logic [32:0] if_to_id_bus;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;

    int checks;
    int failures;

    // model state: fetch address, fetch-valid flag, at most one saved redirect
    logic [31:0] m_pc;
    logic        m_ce;
    logic [31:0] pend_q[$];

    if_stage #(.RESET_PC(32'hBFC0_0000)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .stall           (stall),
        .br_bus          (br_bus),
        .if_to_id_bus    (if_to_id_bus),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_wen   (inst_sram_wen),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'hBFC0_0000 - 32'd4;
        m_ce = 1'b0;
        pend_q.delete();
    endtask

    // One clock edge of the fetch rules, written from the behavioural view.
    task automatic model_edge(input bit s, input bit be, input logic [31:0] ba);
        logic [31:0] target;
        if (be)                   target = ba;
        else if (pend_q.size()>0) target = pend_q[0];
        else                      target = m_pc + 32'd4;
        if (!m_ce) begin
            if (!s) begin
                m_pc = target;
                m_ce = 1'b1;
            end
        end else if (s) begin
            if (be && pend_q.size() == 0) pend_q.push_back(ba);
        end else begin
            m_pc = target;
            pend_q.delete();
        end
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ".bus"},   64'(if_to_id_bus),    64'({m_ce, m_pc}));
        chk({tag, ".en"},    64'(inst_sram_en),    64'(m_ce));
        chk({tag, ".addr"},  64'(inst_sram_addr),  64'(m_pc));
        chk({tag, ".wen"},   64'(inst_sram_wen),   64'(0));
        chk({tag, ".wdata"}, 64'(inst_sram_wdata), 64'(0));
    endtask

    // Inputs are applied 1ns after an edge; outputs are checked 1ns after the next.
    task automatic cycle(input string tag, input bit s, input bit be, input logic [31:0] ba);
        stall  = {5'($urandom), s};
        br_bus = {be, ba};
        @(posedge clk);
        model_edge(s, be, ba);
        #1;
        check_outs(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        resetn   = 1'b0;
        stall    = 6'b0;
        br_bus   = 33'b0;
        model_reset();

        // reset / boot
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset");
        chk("reset_bus", 64'(if_to_id_bus), 64'({1'b0, 32'hBFBF_FFFC}));
        resetn = 1'b1;
        #1;
        check_outs("post_release");
        cycle("boot0", 1'b0, 1'b0, 32'h0);
        chk("boot_pc", 64'(if_to_id_bus), 64'({1'b1, 32'hBFC0_0000}));
        cycle("boot1", 1'b0, 1'b0, 32'h0);
        cycle("boot2", 1'b0, 1'b0, 32'h0);
        chk("boot2_pc", 64'(inst_sram_addr), 64'(32'hBFC0_0008));

        // branch
        cycle("br", 1'b0, 1'b1, 32'hBFC0_0100);
        chk("br_pc", 64'(inst_sram_addr), 64'(32'hBFC0_0100));
        cycle("br_next", 1'b0, 1'b0, 32'h0);

        // stall with capture in first stall cycle only
        cycle("stall0", 1'b1, 1'b1, 32'h8000_0040);
        cycle("stall1", 1'b1, 1'b0, 32'h0);
        cycle("stall2", 1'b1, 1'b0, 32'h0);
        chk("stall_frozen", 64'(inst_sram_addr), 64'(32'hBFC0_0104));
        cycle("release", 1'b0, 1'b0, 32'h0);
        chk("release_pc", 64'(inst_sram_addr), 64'(32'h8000_0040));
        cycle("after_rel", 1'b0, 1'b0, 32'h0);
        chk("pend_cleared", 64'(inst_sram_addr), 64'(32'h8000_0044));

        // first capture wins over later ones in the same window
        cycle("cap_a", 1'b1, 1'b1, 32'h0000_1000);
        cycle("cap_b", 1'b1, 1'b1, 32'h0000_3000);
        cycle("cap_rel", 1'b0, 1'b0, 32'h0);
        chk("first_kept", 64'(inst_sram_addr), 64'(32'h0000_1000));

        // live branch at release beats the captured one
        cycle("pri_a", 1'b1, 1'b1, 32'h0000_1000);
        cycle("pri_c", 1'b1, 1'b1, 32'h0000_3000);
        cycle("pri_rel", 1'b0, 1'b1, 32'h0000_2000);
        chk("live_wins", 64'(inst_sram_addr), 64'(32'h0000_2000));
        cycle("pri_next", 1'b0, 1'b0, 32'h0);
        chk("pri_cleared", 64'(inst_sram_addr), 64'(32'h0000_2004));

        // wrap
        cycle("wrap0", 1'b0, 1'b1, 32'hFFFF_FFF8);
        cycle("wrap1", 1'b0, 1'b0, 32'h0);
        cycle("wrap2", 1'b0, 1'b0, 32'h0);
        chk("wrap_pc", 64'(inst_sram_addr), 64'(32'h0000_0000));

        // async reset mid-stall with a pending redirect
        cycle("hold_cap", 1'b1, 1'b1, 32'h0000_5000);
        cycle("hold_keep", 1'b1, 1'b0, 32'h0);
        resetn = 1'b0;
        #1;
        model_reset();
        check_outs("async_rst");
        chk("async_rst_bus", 64'(if_to_id_bus), 64'({1'b0, 32'hBFBF_FFFC}));
        #2;
        resetn = 1'b1;
        cycle("boot_stall", 1'b1, 1'b1, 32'h0000_7000);
        chk("boot_stall_en", 64'(inst_sram_en), 64'(0));
        cycle("reboot0", 1'b0, 1'b0, 32'h0);
        chk("reboot_pc", 64'(inst_sram_addr), 64'(32'hBFC0_0000));
        cycle("reboot1", 1'b0, 1'b0, 32'h0);
        chk("no_old_pend", 64'(inst_sram_addr), 64'(32'hBFC0_0004));

        // random traffic
        for (int i = 0; i < 400; i++) begin
            bit s, be;
            logic [31:0] ba;
            s  = ($urandom_range(0, 99) < 35);
            be = ($urandom_range(0, 99) < 20);
            ba = $urandom;
            if ($urandom_range(0, 99) < 2) begin
                resetn = 1'b0;
                #1;
                model_reset();
                check_outs("rnd_rst");
                #1;
                resetn = 1'b1;
            end
            cycle("rnd", s, be, ba);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
